// File: rtl/image_streamer_if.sv
// Memory read port plus byte stream towards the sink, bundled for the streamer.
// Master side is the streamer; slave side is the memory model / byte sink.
// The sink pushes back through tx_ready; the memory has no backpressure.
interface image_streamer_if #(
    parameter int ADDR_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/image_streamer.sv
// Streams a byte range out of 32-bit word memory, little-endian, one byte per accepted beat.
// Latency: read + capture cycle per word, so at best 4 bytes every 6 cycles; done 2 cycles after a zero-length start.
// Backpressure: tx_ready low holds tx_data/idx/count in place and no new read is issued.
module image_streamer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    image_streamer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        SEND   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            // done lands in the cycle after FINISH, together with busy dropping
            done_q  <= (state_q == FINISH);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        word_d  = word_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
                    rem_d   = length;
                    state_d = (length == '0) ? FINISH : READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                word_d  = bus.mem_rdata;
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    rem_d = rem_q - LEN_W'(1);
                    // a partial last word ends here, so its upper bytes are never shown
                    if (rem_q == LEN_W'(1)) begin
                        state_d = FINISH;
                    end else if (idx_q == 2'd3) begin
                        addr_d  = addr_q + ADDR_W'(4);
                        state_d = READ;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_rd_en = (state_q == READ);
    assign bus.mem_addr  = addr_q;
    assign bus.tx_valid  = (state_q == SEND);
    assign bus.tx_data   = word_q[{idx_q, 3'b000} +: 8];
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: memory model, stream monitor and hand-computed expectations.
module tb_image_streamer;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;

    image_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    image_streamer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  rx_q[$];
    logic [31:0] rd_q[$];
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'h4433_2211;
            32'h0000_0104: mem_word = 32'h8877_6655;
            32'hFFFF_FFFC: mem_word = 32'hA3A2_A1A0;
            32'h0000_0000: mem_word = 32'hB3B2_B1B0;
            default:       mem_word = {a[15:0], 16'hC0DE};
        endcase
    endfunction

    function automatic logic [63:0] rx_packed();
        logic [63:0] r;
        r = '0;
        foreach (rx_q[i]) begin
            if (i < 8) r[i*8 +: 8] = rx_q[i];
        end
        return r;
    endfunction

    // one-cycle read latency memory
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem_word(bus.mem_addr);
    end

    // inputs change just after posedge, so negedge sees what the next edge will use
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_en === 1'b1) rd_q.push_back(bus.mem_addr);
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) rx_q.push_back(bus.tx_data);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rd_q.delete();
        done_cnt = 0;
    endtask

    task automatic kick(input logic [31:0] a, input logic [15:0] l);
        base_addr = a;
        length    = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            step();
            cycles++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int c;
        c = 0;
        while (rx_q.size() < n && c < 200) begin
            step();
            c++;
        end
        check({tag, "_bytes_reached"}, 64'(rx_q.size()), 64'(n));
    endtask

    initial begin
        int cyc;

        rst          = 1'b1;
        start        = 1'b1;
        base_addr    = 32'h100;
        length       = 16'd4;
        bus.tx_ready = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_rd_en",    bus.mem_rd_en, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data",  bus.tx_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        step();
        clear_logs();

        // full 8-byte transfer at best throughput
        kick(32'h100, 16'd8);
        wait_done("t1", cyc);
        check("t1_cycles", 64'(cyc), 13);
        step(); step();
        check("t1_nreads", 64'(rd_q.size()), 2);
        check("t1_rd0",    rd_q[0], 32'h100);
        check("t1_rd1",    rd_q[1], 32'h104);
        check("t1_nbytes", 64'(rx_q.size()), 8);
        check("t1_data",   rx_packed(), 64'h8877_6655_4433_2211);
        check("t1_ndone",  64'(done_cnt), 1);

        // partial last word, unaligned base
        clear_logs();
        kick(32'h103, 16'd5);
        wait_done("t2", cyc);
        step(); step();
        check("t2_nreads", 64'(rd_q.size()), 2);
        check("t2_rd0",    rd_q[0], 32'h100);
        check("t2_rd1",    rd_q[1], 32'h104);
        check("t2_nbytes", 64'(rx_q.size()), 5);
        check("t2_data",   rx_packed(), 64'h55_4433_2211);

        // zero length
        clear_logs();
        kick(32'h100, 16'd0);
        check("t3_busy_c1", busy, 1);
        check("t3_done_c1", done, 0);
        step();
        check("t3_done_c2", done, 1);
        check("t3_busy_c2", busy, 0);
        step();
        check("t3_done_c3", done, 0);
        check("t3_nreads",  64'(rd_q.size()), 0);
        check("t3_nbytes",  64'(rx_q.size()), 0);

        // backpressure holds the second byte
        clear_logs();
        kick(32'h100, 16'd8);
        wait_bytes("t4", 1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_data",  bus.tx_data, 8'h22);
            check("t4_hold_valid", bus.tx_valid, 1);
            check("t4_hold_rd_en", bus.mem_rd_en, 0);
        end
        bus.tx_ready = 1'b1;
        wait_done("t4", cyc);
        step(); step();
        check("t4_nbytes", 64'(rx_q.size()), 8);
        check("t4_data",   rx_packed(), 64'h8877_6655_4433_2211);
        check("t4_nreads", 64'(rd_q.size()), 2);

        // start while busy and in FINISH is dropped
        clear_logs();
        kick(32'h100, 16'd8);
        wait_bytes("t5a", 3);
        kick(32'h200, 16'd0);
        wait_bytes("t5b", 8);
        check("t5_finish_busy", busy, 1);
        kick(32'h200, 16'd4);
        check("t5_done", done, 1);
        repeat (6) step();
        check("t5_idle",   busy, 0);
        check("t5_nreads", 64'(rd_q.size()), 2);
        check("t5_nbytes", 64'(rx_q.size()), 8);
        check("t5_ndone",  64'(done_cnt), 1);
        check("t5_data",   rx_packed(), 64'h8877_6655_4433_2211);
        clear_logs();
        kick(32'h100, 16'd4);
        wait_done("t5c", cyc);
        step(); step();
        check("t5c_nreads", 64'(rd_q.size()), 1);
        check("t5c_nbytes", 64'(rx_q.size()), 4);
        check("t5c_data",   rx_packed(), 64'h4433_2211);

        // reset mid-transfer, with start asserted alongside it
        clear_logs();
        kick(32'h100, 16'd8);
        wait_bytes("t6", 2);
        rst       = 1'b1;
        start     = 1'b1;
        base_addr = 32'h104;
        length    = 16'd4;
        step();
        check("t6_busy",     busy, 0);
        check("t6_done",     done, 0);
        check("t6_rd_en",    bus.mem_rd_en, 0);
        check("t6_tx_valid", bus.tx_valid, 0);
        check("t6_tx_data",  bus.tx_data, 0);
        check("t6_mem_addr", bus.mem_addr, 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) step();
        check("t6_nbytes", 64'(rx_q.size()), 2);
        check("t6_ndone",  64'(done_cnt), 0);
        check("t6_nreads", 64'(rd_q.size()), 1);
        check("t6_idle",   busy, 0);

        // word address wraps past the top of the address space
        clear_logs();
        kick(32'hFFFF_FFFD, 16'd8);
        wait_done("t7", cyc);
        step(); step();
        check("t7_rd0",  rd_q[0], 32'hFFFF_FFFC);
        check("t7_rd1",  rd_q[1], 32'h0);
        check("t7_data", rx_packed(), 64'hB3B2_B1B0_A3A2_A1A0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/image_streamer.md
IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the data-memory byte-address width.
REQ-002 The block SHALL have parameter LEN_W, default 16, the transfer-length width in bytes.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a transfer.
REQ-006 The block SHALL have port base_addr, input, ADDR_W, the byte address of the first word; bits [1:0] are ignored.
REQ-007 The block SHALL have port length, input, LEN_W, the number of bytes to stream.
REQ-008 The block SHALL have port mem_rd_en, output, 1, the data-memory read strobe.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W, the data-memory word-aligned byte address.
REQ-010 The block SHALL have port mem_rdata, input, 32, the read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 The block SHALL have port tx_data, output, 8, the streamed byte.
REQ-012 The block SHALL have port tx_valid, output, 1, meaning tx_data holds a valid byte.
REQ-013 The block SHALL have port tx_ready, input, 1, the sink acceptance signal.
REQ-014 The block SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-015 The block SHALL have port done, output, 1, a one-cycle pulse marking the end of a transfer.

Function
REQ-016 The block SHALL implement the states IDLE, READ, WAIT, SEND and FINISH.
REQ-017 In IDLE, start SHALL latch {base_addr[ADDR_W-1:2],2'b00} and length and go to READ, or go to FINISH if length==0.
REQ-018 In READ, the block SHALL assert mem_rd_en for exactly one cycle with mem_addr equal to the current word address, then go to WAIT.
REQ-019 In WAIT, the block SHALL capture mem_rdata into a 32-bit word buffer, set the byte index to 0 and go to SEND.
REQ-020 In SEND, tx_valid SHALL be 1 and tx_data SHALL be word[8*idx+7:8*idx], emitting little-endian, byte 0 first.
REQ-021 A byte SHALL transfer only on a cycle with tx_valid && tx_ready; tx_data SHALL hold stable while tx_valid && !tx_ready.
REQ-022 On each transfer the remaining count SHALL decrement by 1; at 0 go to FINISH, else at idx==3 add 4 to the word address and go to READ, else increment idx.
REQ-023 A final partial word (length mod 4 != 0) SHALL emit only the remaining low bytes; its unused upper bytes SHALL never appear.
REQ-024 Word-address increment SHALL wrap modulo 2^ADDR_W without error.
REQ-025 FINISH SHALL assert done for exactly one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-026 start SHALL be ignored in every state other than IDLE, including the FINISH cycle.
REQ-027 Throughput SHALL be at most 4 bytes per 6 cycles with tx_ready held high (READ, WAIT, 4x SEND).
REQ-028 mem_rd_en SHALL be 0 in every state other than READ.
REQ-029 tx_valid SHALL be 0 in every state other than SEND.

Reset
REQ-030 When rst=1 at a clock edge, the state SHALL become IDLE and mem_rd_en, tx_valid, busy and done SHALL become 0, with tx_data, mem_addr and the counters set to 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no further bytes and no done pulse.
REQ-032 start sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-033 The bench SHALL drive base_addr=0x100, length=8, tx_ready=1 -> reads at 0x100 and 0x104; with mem words 0x44332211 and 0x88776655, bytes 11..88 in order; one done pulse.
REQ-034 The bench SHALL drive length=5 -> 5 bytes 11,22,33,44,55; exactly two reads; bytes 66..88 never emitted.
REQ-035 The bench SHALL drive length=0 -> no mem_rd_en, no tx_valid; done asserted 2 cycles after start.
REQ-036 The bench SHALL hold tx_ready=0 for 3 cycles while tx_valid is high -> tx_data unchanged, count not decremented, no new read issued.
REQ-037 The bench SHALL pulse start while busy, and pulse it in the FINISH cycle -> both ignored; a second start after returning to IDLE is accepted.
REQ-038 The bench SHALL assert rst after 2 bytes of an 8-byte transfer -> the next cycle is IDLE with all outputs 0 and no done pulse.
